// File: rtl/sdram_req_queue_pkg.sv
// Shared types for the SDRAM request queue: default address width, queued request record, issuer states.
package sdram_pkg;

    localparam int SDRAM_HADDR_WIDTH = 24;

    typedef struct packed {
        logic                         we;
        logic [SDRAM_HADDR_WIDTH-1:0] addr;
        logic [15:0]                  wdata;
    } sdram_req_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } issue_state_e;

endpackage

// File: rtl/sdram_req_queue_if.sv
// Client-side request/response and controller-side command signals of the SDRAM request queue.
interface sdram_req_queue_if
    import sdram_pkg::*;
#(
    parameter int HADDR_WIDTH = SDRAM_HADDR_WIDTH
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [HADDR_WIDTH-1:0] req_addr;
    logic [15:0]            req_wdata;
    logic                   rsp_valid;
    logic [15:0]            rsp_data;
    logic [HADDR_WIDTH-1:0] wr_addr;
    logic [HADDR_WIDTH-1:0] rd_addr;
    logic [15:0]            wr_data;
    logic                   wr_enable;
    logic                   rd_enable;
    logic [15:0]            rd_data;
    logic                   rd_ready;
    logic                   busy;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rd_data, rd_ready, busy,
        output req_ready, rsp_valid, rsp_data, wr_addr, rd_addr, wr_data, wr_enable, rd_enable
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rd_data, rd_ready, busy,
        input  req_ready, rsp_valid, rsp_data, wr_addr, rd_addr, wr_data, wr_enable, rd_enable
    );
endinterface

// File: rtl/sdram_req_queue_fifo.sv
// Request FIFO for the SDRAM queue; count_o exists only when SDRAM_REQ_QUEUE_LEVEL_EN is defined.
module sdram_req_fifo
    import sdram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  sdram_req_t din_i,
    output sdram_req_t dout_o,
    output logic       full_o,
    output logic       empty_o
`ifdef SDRAM_REQ_QUEUE_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] count_o
`endif
);
    localparam int AW = $clog2(DEPTH);

    sdram_req_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    // Full/empty come straight from the registered count, so a pop never frees room in the same cycle.
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
`ifdef SDRAM_REQ_QUEUE_LEVEL_EN
    assign count_o = count_q;
`endif

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/sdram_req_queue.sv
// SDRAM request queue: buffers client requests and issues them one at a time to the controller.
// Optional fifo_level output is enabled by defining SDRAM_REQ_QUEUE_LEVEL_EN.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | issuer free; pops FIFO head into issue_q when available
// ST_ISSUE     | enable held high until the controller raises busy
// ST_WAIT_DONE | command accepted; waiting for busy to drop
module sdram_req_queue
    import sdram_pkg::*;
#(
    parameter int HADDR_WIDTH = SDRAM_HADDR_WIDTH,
    parameter int DEPTH       = 4
) (
    input logic                clk,
    input logic                rst_n,
    sdram_req_queue_if.slave   bus
`ifdef SDRAM_REQ_QUEUE_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] fifo_level
`endif
);
    sdram_req_t   req_in;
    sdram_req_t   head;
    sdram_req_t   issue_q;
    issue_state_e state_q;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;
    logic         rd_en_q;
    logic         wr_en_q;
    logic         rd_pend_q;
    logic         rsp_valid_q;
    logic [15:0]  rsp_data_q;

    assign req_in = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
    assign pop    = (state_q == ST_IDLE) & ~fifo_empty;

    sdram_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.req_valid),
        .pop_i   (pop),
        .din_i   (req_in),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
`ifdef SDRAM_REQ_QUEUE_LEVEL_EN
        ,
        .count_o (fifo_level)
`endif
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            issue_q     <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            // rd_pend_q makes the read return one-shot; it is never set for writes.
            if (rd_pend_q && bus.rd_ready && (state_q != ST_IDLE)) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= bus.rd_data;
                rd_pend_q   <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        issue_q   <= head;
                        wr_en_q   <= head.we;
                        rd_en_q   <= ~head.we;
                        rd_pend_q <= ~head.we;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.busy) begin
                        wr_en_q <= 1'b0;
                        rd_en_q <= 1'b0;
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!bus.busy) begin
                        rd_pend_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = ~fifo_full;
    assign bus.wr_addr   = issue_q.addr;
    assign bus.rd_addr   = issue_q.addr;
    assign bus.wr_data   = issue_q.wdata;
    assign bus.wr_enable = wr_en_q;
    assign bus.rd_enable = rd_en_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_sdram_req_queue.sv
// Randomized scoreboard bench for sdram_req_queue with a behavioural SDRAM controller model.
module tb_sdram_req_queue;
    localparam int DEPTH = 4;

    typedef struct {
        bit          we;
        logic [23:0] addr;
        logic [15:0] data;
    } cmd_t;

    logic clk;
    logic rst_n;
    sdram_req_queue_if #(.HADDR_WIDTH(24)) bus ();
`ifdef SDRAM_REQ_QUEUE_LEVEL_EN
    logic [$clog2(DEPTH):0] fifo_level;
`endif

    sdram_req_queue #(.HADDR_WIDTH(24), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SDRAM_REQ_QUEUE_LEVEL_EN
        ,
        .fifo_level (fifo_level)
`endif
    );

    int checks = 0;
    int errors = 0;

    cmd_t        exp_iss[$];
    logic [15:0] exp_rsp[$];
    logic [15:0] ref_mem[int];
    logic [15:0] bfm_mem[int];

    int cyc = 0, acc = 0, iss = 0, tot_iss = 0, tot_rsp = 0;
    int en_len = 0, last_en_len = 0, en_falls = 0, last_rr = -100;
    bit en, prev_en, prev_busy, cur_we, last_we;
    cmd_t c;

    int force_d = 0;
    bit hold_busy = 0;
    int bst = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] dflt(input int a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_iss.delete();
            exp_rsp.delete();
            acc = 0; iss = 0; prev_en = 0; prev_busy = 0;
        end else begin
            en = bus.rd_enable | bus.wr_enable;
            chk(!(bus.rd_enable && bus.wr_enable), "en_overlap", {bus.rd_enable, bus.wr_enable}, 0);
            if (prev_en) begin
                if (prev_busy) chk(!en, "en_drop_after_busy", en, 0);
                else           chk(en, "en_hold_until_busy", en, 1);
            end
            if (en && !prev_en) begin
                iss++; tot_iss++; en_len = 0; cur_we = bus.wr_enable;
                if (exp_iss.size() == 0) begin
                    chk(0, "issue_unexpected", bus.rd_addr, 0);
                end else begin
                    c = exp_iss.pop_front();
                    chk(bus.wr_enable == c.we, "issue_we", bus.wr_enable, c.we);
                    chk(bus.rd_addr == c.addr && bus.wr_addr == c.addr, "issue_addr", bus.rd_addr, c.addr);
                    if (c.we) chk(bus.wr_data == c.data, "issue_wdata", bus.wr_data, c.data);
                end
            end
            if (en) en_len++;
            if (!en && prev_en) begin
                last_en_len = en_len; last_we = cur_we; en_falls++;
            end
            chk(bus.req_ready == ((acc - iss) < DEPTH), "req_ready", bus.req_ready, (acc - iss) < DEPTH);
`ifdef SDRAM_REQ_QUEUE_LEVEL_EN
            chk(int'(fifo_level) == acc - iss, "fifo_level", fifo_level, acc - iss);
`endif
            if (bus.rsp_valid) begin
                tot_rsp++;
                if (exp_rsp.size() == 0) begin
                    chk(0, "rsp_unexpected", bus.rsp_data, 0);
                end else begin
                    logic [15:0] e;
                    e = exp_rsp.pop_front();
                    chk(bus.rsp_data == e, "rsp_data", bus.rsp_data, e);
                end
                chk(cyc == last_rr + 1, "rsp_latency", cyc - last_rr, 1);
            end
            if (bus.rd_ready) last_rr = cyc;
            if (bus.req_valid && bus.req_ready) begin
                acc++;
                c.we = bus.req_we; c.addr = bus.req_addr; c.data = bus.req_wdata;
                exp_iss.push_back(c);
                if (bus.req_we) ref_mem[int'(bus.req_addr)] = bus.req_wdata;
                else exp_rsp.push_back(ref_mem.exists(int'(bus.req_addr)) ?
                                       ref_mem[int'(bus.req_addr)] : dflt(int'(bus.req_addr)));
            end
            prev_en = en;
            prev_busy = bus.busy;
        end
    end

    // Controller model: accepts after dly cycles of enable, stays busy blen cycles,
    // returns read data once while busy; pulses rd_ready spuriously during writes and idle.
    initial begin
        int cnt, dly, k, blen, rdy_at;
        bit cmd_we, do_acc;
        logic [23:0] cmd_addr;
        logic [15:0] cmd_data;
        bus.busy = 0; bus.rd_ready = 0; bus.rd_data = 0;
        cnt = 0; dly = 1; k = 0; blen = 1; rdy_at = 1; cmd_we = 0; cmd_addr = 0; cmd_data = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                bst = 0; bus.busy = 0; bus.rd_ready = 0;
            end else begin
                bus.rd_ready = 0;
                bus.rd_data = 16'($urandom);
                do_acc = 0;
                case (bst)
                    0: if (bus.rd_enable || bus.wr_enable) begin
                           cnt = 1;
                           dly = (force_d != 0) ? force_d : int'($urandom_range(1, 4));
                           cmd_we = bus.wr_enable; cmd_addr = bus.wr_addr; cmd_data = bus.wr_data;
                           if (cnt >= dly) do_acc = 1; else bst = 1;
                       end else if ($urandom_range(0, 7) == 0) begin
                           bus.rd_ready = 1;
                       end
                    1: begin
                           cnt++;
                           if (cnt >= dly) do_acc = 1;
                       end
                    default: if (!hold_busy) begin
                           k++;
                           if (k == rdy_at) begin
                               bus.rd_ready = 1;
                               if (!cmd_we) bus.rd_data = bfm_mem.exists(int'(cmd_addr)) ?
                                                          bfm_mem[int'(cmd_addr)] : dflt(int'(cmd_addr));
                           end
                           if (k >= blen) begin
                               bus.busy = 0; bst = 0;
                           end
                       end
                endcase
                if (do_acc) begin
                    bus.busy = 1; bst = 2; k = 0;
                    blen = int'($urandom_range(1, 3));
                    rdy_at = int'($urandom_range(1, blen));
                    if (cmd_we) bfm_mem[int'(cmd_addr)] = cmd_data;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input bit we, input logic [23:0] a, input logic [15:0] d);
        bit ok; int t;
        ok = 0; t = 0;
        bus.req_valid = 1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
        while (!ok && t < 300) begin
            @(negedge clk); ok = bus.req_ready;
            tick(); t++;
        end
        bus.req_valid = 0;
        chk(ok, "push_accept", t, 300);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_iss.size() != 0 || exp_rsp.size() != 0 || bst != 0) && t < 3000) begin
            tick(); t++;
        end
        repeat (3) tick();
        chk(t < 3000, "drain_timeout", t, 3000);
    endtask

    task automatic wait_fall();
        int f0, t;
        f0 = en_falls; t = 0;
        while (en_falls == f0 && t < 100) begin
            @(negedge clk); t++;
        end
        chk(en_falls != f0, "enable_fall_timeout", t, 100);
    endtask

    task automatic wait_bst2();
        int t = 0;
        while (bst != 2 && t < 100) begin
            tick(); t++;
        end
        tick();
        chk(bst == 2, "bfm_accept_timeout", t, 100);
    endtask

    initial begin
        int snap_rsp, snap_iss;
        rst_n = 0;
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0;
        repeat (3) tick();
        rst_n = 1;

        // Reset state
        @(negedge clk);
        chk(bus.req_ready == 1, "rst_req_ready", bus.req_ready, 1);
        chk(bus.rsp_valid == 0 && bus.rsp_data == 0, "rst_rsp", {bus.rsp_valid, bus.rsp_data}, 0);
        chk(!bus.rd_enable && !bus.wr_enable, "rst_enables", {bus.rd_enable, bus.wr_enable}, 0);
        chk(bus.wr_addr == 0 && bus.rd_addr == 0 && bus.wr_data == 0, "rst_addr_data", bus.wr_addr, 0);
        tick();

        // Single write, controller accepts after 2 enable cycles
        force_d = 2;
        snap_rsp = tot_rsp;
        push(1, 24'h123456, 16'hBEEF);
        wait_fall();
        chk(last_en_len == 2, "write_en_len", last_en_len, 2);
        chk(last_we == 1, "write_is_write", last_we, 1);
        drain();
        chk(tot_rsp == snap_rsp, "write_no_rsp", tot_rsp - snap_rsp, 0);
        force_d = 0;

        // Single read returning 0xA5A5
        bfm_mem[16] = 16'hA5A5;
        ref_mem[16] = 16'hA5A5;
        snap_rsp = tot_rsp;
        push(0, 24'h000010, 16'h0);
        drain();
        chk(tot_rsp == snap_rsp + 1, "read_one_rsp", tot_rsp - snap_rsp, 1);

        // Fill: issuer held in WAIT_DONE, four queue, fifth held off until busy releases
        hold_busy = 1;
        push(1, 24'h000100, 16'h1111);
        wait_bst2();
        push(0, 24'h000100, 16'h0);
        push(1, 24'h000101, 16'h2222);
        push(0, 24'h000101, 16'h0);
        push(1, 24'h000102, 16'h3333);
        fork
            push(0, 24'h000102, 16'h0);
            begin
                repeat (6) begin
                    @(negedge clk);
                    chk(bus.req_ready == 0, "full_holdoff", bus.req_ready, 0);
                end
                hold_busy = 0;
            end
        join
        drain();

        // Refresh: busy stays low for 12 cycles after issue
        force_d = 13;
        snap_rsp = tot_rsp;
        push(0, 24'h000200, 16'h0);
        wait_fall();
        chk(last_en_len >= 13, "refresh_en_len", last_en_len, 13);
        chk(last_we == 0, "refresh_is_read", last_we, 0);
        drain();
        chk(tot_rsp == snap_rsp + 1, "refresh_one_rsp", tot_rsp - snap_rsp, 1);
        force_d = 0;

        // Reset during WAIT_DONE of a read with two reads queued
        hold_busy = 1;
        push(0, 24'h000300, 16'h0);
        wait_bst2();
        push(0, 24'h000301, 16'h0);
        push(0, 24'h000302, 16'h0);
        snap_rsp = tot_rsp;
        snap_iss = tot_iss;
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        hold_busy = 0;
        repeat (20) @(negedge clk);
        chk(tot_rsp == snap_rsp, "reset_no_rsp", tot_rsp - snap_rsp, 0);
        chk(tot_iss == snap_iss, "reset_no_issue", tot_iss - snap_iss, 0);
        chk(bus.req_ready == 1, "reset_req_ready", bus.req_ready, 1);
        tick();

        // Alternating write/read to one address
        for (int i = 0; i < 6; i++) begin
            push(1, 24'h0ABCDE, 16'($urandom));
            push(0, 24'h0ABCDE, 16'h0);
        end
        drain();

        // Random traffic over a small address window to exercise hazards
        for (int i = 0; i < 150; i++) begin
            push(1'($urandom_range(0, 1)), 24'h3F0000 + 24'($urandom_range(0, 7)), 16'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();

        chk(exp_iss.size() == 0, "end_issue_queue_empty", exp_iss.size(), 0);
        chk(exp_rsp.size() == 0, "end_rsp_queue_empty", exp_rsp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
